// File: rtl/gpr_writeback_arbiter.sv
// gpr_writeback_arbiter
//   Single write port arbiter for the general purpose register file.
//   Primary (ALU/load) results always win; secondary (mul/div) results are
//   buffered in a DEPTH-entry FIFO and drained when the primary is idle.
//   A primary write squashes older queued writes to the same register (WAW).
//   A starvation counter raises an advisory stall once draining has been
//   blocked for STARVE_LIMIT cycles.
//   Optional feature macro: WB_SCOREBOARD_EN (registered pending-write mask).
module gpr_writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_pri_valid,
  input  logic [4:0]  i_pri_reg,
  input  logic [31:0] i_pri_data,
  input  logic        i_sec_valid,
  output logic        o_sec_ready,
  input  logic [4:0]  i_sec_reg,
  input  logic [31:0] i_sec_data,
  output logic        o_write_enable,
  output logic [4:0]  o_write_reg,
  output logic [31:0] o_write_data,
  output logic        o_stall_pri,
  output logic [31:0] o_pending_mask
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  // Queue storage and control state
  logic [4:0]       fifo_reg_r  [DEPTH];
  logic [31:0]      fifo_data_r [DEPTH];
  logic [DEPTH-1:0] fifo_vld_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [STV_W-1:0] starve_r;
  logic             stall_r;
  logic             we_r;
  logic [4:0]       wreg_r;
  logic [31:0]      wdata_r;

  // Next-state values
  logic [4:0]       fifo_reg_s  [DEPTH];
  logic [31:0]      fifo_data_s [DEPTH];
  logic [DEPTH-1:0] fifo_vld_s;
  logic [PTR_W-1:0] rd_ptr_s;
  logic [PTR_W-1:0] wr_ptr_s;
  logic [CNT_W-1:0] count_s;
  logic [STV_W-1:0] starve_s;
  logic             stall_s;
  logic             we_s;
  logic [4:0]       wreg_s;
  logic [31:0]      wdata_s;

  logic pri_wr_s;
  logic sec_acc_s;
  logic empty_s;
  logic any_vld_s;
  logic sec_squash_s;
  logic push_s;
  logic pop_s;

  // Ready depends on occupancy only, never on a same-cycle pop
  assign o_sec_ready    = (count_r < CNT_W'(DEPTH));
  assign o_write_enable = we_r;
  assign o_write_reg    = wreg_r;
  assign o_write_data   = wdata_r;
  assign o_stall_pri    = stall_r;

  // Arbitration, squash, push/pop and starvation next-state logic
  always_comb begin
    pri_wr_s     = i_pri_valid && (i_pri_reg != 5'd0);
    sec_acc_s    = i_sec_valid && o_sec_ready;
    empty_s      = (count_r == CNT_W'(0));
    any_vld_s    = |fifo_vld_r;
    sec_squash_s = pri_wr_s && (i_sec_reg == i_pri_reg);

    fifo_reg_s  = fifo_reg_r;
    fifo_data_s = fifo_data_r;
    fifo_vld_s  = fifo_vld_r;
    rd_ptr_s    = rd_ptr_r;
    wr_ptr_s    = wr_ptr_r;
    count_s     = count_r;
    we_s        = 1'b0;
    wreg_s      = wreg_r;
    wdata_s     = wdata_r;
    pop_s       = 1'b0;
    push_s      = 1'b0;

    if (pri_wr_s) begin
      we_s    = 1'b1;
      wreg_s  = i_pri_reg;
      wdata_s = i_pri_data;
      // Older queued writes to the same register are now stale
      for (int i = 0; i < DEPTH; i++) begin
        if (fifo_reg_r[i] == i_pri_reg) begin
          fifo_vld_s[i] = 1'b0;
        end else begin
          fifo_vld_s[i] = fifo_vld_s[i];
        end
      end
    end else if (!empty_s) begin
      pop_s = 1'b1;
      if (fifo_vld_r[rd_ptr_r]) begin
        we_s    = 1'b1;
        wreg_s  = fifo_reg_r[rd_ptr_r];
        wdata_s = fifo_data_r[rd_ptr_r];
      end else begin
        we_s = 1'b0;
      end
      fifo_vld_s[rd_ptr_r] = 1'b0;
      rd_ptr_s             = rd_ptr_r + PTR_W'(1);
    end else if (sec_acc_s && (i_sec_reg != 5'd0)) begin
      // Bypass: empty queue and idle primary, write straight through
      we_s    = 1'b1;
      wreg_s  = i_sec_reg;
      wdata_s = i_sec_data;
    end else begin
      we_s = 1'b0;
    end

    push_s = sec_acc_s && (i_sec_reg != 5'd0) && !sec_squash_s && (pri_wr_s || !empty_s);
    if (push_s) begin
      fifo_reg_s[wr_ptr_r]  = i_sec_reg;
      fifo_data_s[wr_ptr_r] = i_sec_data;
      fifo_vld_s[wr_ptr_r]  = 1'b1;
      wr_ptr_s              = wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_s = wr_ptr_r;
    end

    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CNT_W'(1);
      2'b01:   count_s = count_r - CNT_W'(1);
      default: count_s = count_r;
    endcase

    if (pop_s || empty_s) begin
      starve_s = STV_W'(0);
    end else if (pri_wr_s && any_vld_s && (starve_r < STV_W'(STARVE_LIMIT))) begin
      starve_s = starve_r + STV_W'(1);
    end else begin
      starve_s = starve_r;
    end
    stall_s = (starve_s == STV_W'(STARVE_LIMIT));
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_reg_r[i]  <= 5'd0;
        fifo_data_r[i] <= 32'd0;
      end
      fifo_vld_r <= '0;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      count_r    <= '0;
      starve_r   <= '0;
      stall_r    <= 1'b0;
      we_r       <= 1'b0;
      wreg_r     <= 5'd0;
      wdata_r    <= 32'd0;
    end else begin
      fifo_reg_r  <= fifo_reg_s;
      fifo_data_r <= fifo_data_s;
      fifo_vld_r  <= fifo_vld_s;
      rd_ptr_r    <= rd_ptr_s;
      wr_ptr_r    <= wr_ptr_s;
      count_r     <= count_s;
      starve_r    <= starve_s;
      stall_r     <= stall_s;
      we_r        <= we_s;
      wreg_r      <= wreg_s;
      wdata_r     <= wdata_s;
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [31:0] mask_s;
  logic [31:0] mask_r;

  function automatic logic [31:0] reg_onehot(input logic [4:0] r);
    logic [31:0] v;
    v    = 32'h0;
    v[r] = 1'b1;
    return v;
  endfunction

  // Pending mask reflects the queue contents after this edge's push/pop/squash
  always_comb begin
    mask_s = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_vld_s[i]) begin
        mask_s = mask_s | reg_onehot(fifo_reg_s[i]);
      end else begin
        mask_s = mask_s;
      end
    end
  end

  // Pending mask register
  always_ff @(posedge clock) begin
    if (!reset) begin
      mask_r <= 32'h0;
    end else begin
      mask_r <= mask_s;
    end
  end

  assign o_pending_mask = mask_r;
`else
  assign o_pending_mask = 32'h0;
`endif

endmodule
